// File: rtl/ss_fifo_sync.sv
// ss_fifo_sync: single-clock first-word-fall-through FIFO.
// Holds 2**Bw_a words of Bw_d bits. Pointers carry one extra wrap bit so that
// full and empty are distinguishable with all 2**Bw_a entries usable.
// The head word is always presented on rd_do; rd_en pops it.
module ss_fifo_sync #(
    parameter int Bw_d = 8,
    parameter int Bw_a = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [Bw_d-1:0] wr_di,
    input  logic            wr_en,
    output logic            wr_rdy,
    input  logic            rd_en,
    output logic            rd_rdy,
    output logic [Bw_d-1:0] rd_do
);

    localparam int Depth = 2 ** Bw_a;

    logic [Bw_d-1:0] r_mem [Depth];
    logic [Bw_a:0]   r_wp;
    logic [Bw_a:0]   r_rp;

    logic w_empty;
    logic w_full;
    logic w_wr_fire;
    logic w_rd_fire;

    assign w_empty   = (r_wp == r_rp);
    assign w_full    = (r_wp[Bw_a-1:0] == r_rp[Bw_a-1:0]) && (r_wp[Bw_a] != r_rp[Bw_a]);
    assign w_wr_fire = wr_en && !w_full;
    assign w_rd_fire = rd_en && !w_empty;

    assign wr_rdy = !w_full;
    assign rd_rdy = !w_empty;

    // Head word is read straight from storage so it is visible without a pop.
    assign rd_do = r_mem[r_rp[Bw_a-1:0]];

    // Storage write; contents are never cleared, stale words are unobservable
    // because the pointers define what is valid. Reset blocks writes.
    always_ff @(posedge clk) begin
        if (reset && w_wr_fire) begin
            r_mem[r_wp[Bw_a-1:0]] <= wr_di;
        end
    end

    // Pointer update; reset (active low) wins over any request in that cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_wr_fire) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_rd_fire) begin
                r_rp <= r_rp + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ss_fifo_sync.sv
// tb_ss_fifo_sync: directed stimulus with a scoreboard queue of expected
// read data; a separate monitor pops and compares on every accepted read.
module tb_ss_fifo_sync;

    logic       clk;
    logic       reset;
    logic [7:0] wr_di;
    logic       wr_en;
    logic       wr_rdy;
    logic       rd_en;
    logic       rd_rdy;
    logic [7:0] rd_do;

    int total;
    int bad;
    logic [7:0] exp_q[$];

    ss_fifo_sync #(.Bw_d(8), .Bw_a(5)) dut (
        .clk    (clk),
        .reset  (reset),
        .wr_di  (wr_di),
        .wr_en  (wr_en),
        .wr_rdy (wr_rdy),
        .rd_en  (rd_en),
        .rd_rdy (rd_rdy),
        .rd_do  (rd_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every accepted read must match the head of the scoreboard.
    always @(negedge clk) begin
        logic [7:0] e;
        if (reset === 1'b1 && rd_en === 1'b1 && rd_rdy === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected: rd_do=%02h required=no data available", rd_do);
            end else begin
                e = exp_q.pop_front();
                if (rd_do !== e) begin
                    bad++;
                    $display("FAIL pop_data: rd_do=%02h required=%02h", rd_do, e);
                end else begin
                    $display("pop rd_do=%02h ok", rd_do);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%02h required=%02h", name, act, req);
        end else begin
            $display("check %s=%02h ok", name, act);
        end
    endtask

    task automatic flags(input string name, input logic exp_rd, input logic exp_wr);
        chk({name, "_rd_rdy"}, {7'd0, rd_rdy}, {7'd0, exp_rd});
        chk({name, "_wr_rdy"}, {7'd0, wr_rdy}, {7'd0, exp_wr});
    endtask

    // One clock of stimulus; inputs held across the edge, released 1 after it.
    task automatic step(input logic we, input logic [7:0] d, input logic re);
        wr_en = we;
        wr_di = d;
        rd_en = re;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic wr_push(input logic [7:0] d);
        step(1'b1, d, 1'b0);
        exp_q.push_back(d);
    endtask

    initial begin
        logic [7:0] v;
        total = 0;
        bad   = 0;
        reset = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        wr_di = 8'h00;

        // 1: reset, idle, reads on empty do nothing
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        reset = 1'b1;
        flags("t1_reset", 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        flags("t1_idle", 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
        flags("t1_rd_empty", 1'b0, 1'b1);

        // 2: single word latency
        wr_push(8'h81);
        flags("t2_after_wr", 1'b1, 1'b1);
        chk("t2_head", rd_do, 8'h81);
        step(1'b0, 8'h00, 1'b1);
        flags("t2_after_rd", 1'b0, 1'b1);

        // 3: fill to capacity, overflow write dropped, drain in order
        for (int i = 0; i < 32; i++) begin
            wr_push(8'(i));
            if (i == 30) flags("t3_31_entries", 1'b1, 1'b1);
        end
        flags("t3_full", 1'b1, 1'b0);
        step(1'b1, 8'hFF, 1'b0);
        flags("t3_overflow", 1'b1, 1'b0);
        chk("t3_head", rd_do, 8'h00);
        for (int i = 0; i < 32; i++) step(1'b0, 8'h00, 1'b1);
        flags("t3_drained", 1'b0, 1'b1);

        // 4: three write-20/read-20 rounds across the pointer wrap
        v = 8'h40;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 20; i++) begin
                wr_push(v);
                v = v + 8'd1;
            end
            flags("t4_round_filled", 1'b1, 1'b1);
            for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1);
            flags("t4_round_drained", 1'b0, 1'b1);
        end

        // 5a: full + simultaneous write/read -> pop only
        for (int i = 0; i < 32; i++) wr_push(8'hC0 + 8'(i));
        flags("t5_full", 1'b1, 1'b0);
        step(1'b1, 8'hAA, 1'b1);
        flags("t5_after_full_rw", 1'b1, 1'b1);
        for (int i = 0; i < 31; i++) begin
            step(1'b0, 8'h00, 1'b1);
            if (i == 29) flags("t5_one_left", 1'b1, 1'b1);
        end
        flags("t5_drained", 1'b0, 1'b1);
        // 5b: empty + simultaneous write/read -> write only
        step(1'b1, 8'h55, 1'b1);
        exp_q.push_back(8'h55);
        flags("t5_after_empty_rw", 1'b1, 1'b1);
        chk("t5_head55", rd_do, 8'h55);
        step(1'b0, 8'h00, 1'b1);
        flags("t5_end", 1'b0, 1'b1);

        // 6: reset with a write pending discards contents
        for (int i = 0; i < 10; i++) wr_push(8'h10 + 8'(i));
        flags("t6_ten", 1'b1, 1'b1);
        reset = 1'b0;
        step(1'b1, 8'hEE, 1'b0);
        reset = 1'b1;
        exp_q.delete();
        flags("t6_after_reset", 1'b0, 1'b1);
        wr_push(8'h77);
        chk("t6_head", rd_do, 8'h77);
        step(1'b0, 8'h00, 1'b1);
        flags("t6_end", 1'b0, 1'b1);

        chk("scoreboard_left", 8'(exp_q.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
